// File: rtl/servisia_pkg.sv
// servisia_pkg: shared opcode constant, boot FSM state type and a small
// helper used by the servisia boot loader and its SPI shifter.
package servisia_pkg;

   // SPI NOR "read data" opcode (3-byte address, no dummy cycles)
   localparam logic [7:0] SPI_CMD_READ = 8'h03;

   typedef enum logic [2:0] {
      CMD,
      ADDR,
      DATA,
      WRITE,
      CHECK,
      DONE,
      ERROR
   } boot_state_t;

   // Chip select is held low for every state of the open flash read.
   function automatic logic spi_active(input boot_state_t s);
      return (s == CMD) || (s == ADDR) || (s == DATA) || (s == WRITE) || (s == CHECK);
   endfunction

endpackage

// File: rtl/servisia_spi_shifter.sv
// servisia_spi_shifter: mode-0 SPI bit engine. Divides clk_i down to SCK,
// shifts a byte out on MOSI and a byte in from MISO, both MSB first.
// 'pause' freezes the stream with SCK low; 'byte_done' is high in the cycle
// whose closing edge finishes a byte, so the caller can act on that edge.
module servisia_spi_shifter #(
   parameter int SCK_HALF = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load,
   input  logic       run,
   input  logic       pause,
   input  logic [7:0] tx_data,
   input  logic       spi_miso_i,
   output logic       spi_sck_o,
   output logic       spi_mosi_o,
   output logic [7:0] rx_data,
   output logic       byte_done
);

   localparam int HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
   localparam logic [HW-1:0] HALF_LAST = HW'(SCK_HALF - 1);

   logic [HW-1:0] half_cnt_reg;
   logic          sck_reg;
   logic [2:0]    bit_cnt_reg;
   logic [7:0]    tx_reg;
   logic [7:0]    rx_reg;
   logic          shifting;
   logic          half_end;

   assign shifting   = run && !pause;
   assign half_end   = (half_cnt_reg == HALF_LAST);
   assign byte_done  = shifting && half_end && sck_reg && (bit_cnt_reg == 3'd7);
   assign spi_sck_o  = sck_reg;
   assign spi_mosi_o = tx_reg[7];
   assign rx_data    = rx_reg;

   // SCK divider plus shift registers; MOSI moves on the falling side, MISO sampled on the rising side
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         half_cnt_reg <= '0;
         sck_reg      <= 1'b0;
         bit_cnt_reg  <= 3'd0;
         tx_reg       <= 8'h00;
         rx_reg       <= 8'h00;
      end else if (load) begin
         half_cnt_reg <= '0;
         sck_reg      <= 1'b0;
         bit_cnt_reg  <= 3'd0;
         tx_reg       <= tx_data;
      end else if (!run) begin
         half_cnt_reg <= '0;
         sck_reg      <= 1'b0;
         bit_cnt_reg  <= 3'd0;
      end else if (shifting) begin
         if (!half_end) begin
            half_cnt_reg <= half_cnt_reg + HW'(1);
         end else begin
            half_cnt_reg <= '0;
            sck_reg      <= !sck_reg;
            if (!sck_reg) begin
               rx_reg <= {rx_reg[6:0], spi_miso_i};
            end else if (bit_cnt_reg == 3'd7) begin
               bit_cnt_reg <= 3'd0;
               tx_reg      <= tx_data;
            end else begin
               bit_cnt_reg <= bit_cnt_reg + 3'd1;
               tx_reg      <= {tx_reg[6:0], 1'b0};
            end
         end
      end
   end

endmodule

// File: rtl/servisia_boot_loader.sv
// servisia_boot_loader: copies a MEMSIZE-byte image from SPI NOR flash
// (read opcode 0x03 at FLASH_OFFSET) into external SRAM one byte per write
// strobe, then hands the SRAM port to the SoC and releases its reset.
// Optional feature macro: BOOT_CHECKSUM_EN -- reads one trailer byte after
// the image and only releases the SoC if the 8-bit sum of image plus
// trailer is zero; otherwise parks in ERROR.
module servisia_boot_loader
   import servisia_pkg::*;
#(
   parameter int          MEMSIZE      = 65536,
   parameter int          AW           = $clog2(MEMSIZE),
   parameter logic [23:0] FLASH_OFFSET = 24'h100000,
   parameter int          SCK_HALF     = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   output logic          spi_sck_o,
   output logic          spi_cs_no,
   output logic          spi_mosi_o,
   input  logic          spi_miso_i,
   output logic          sram_we_o,
   output logic [AW-1:0] sram_addr_o,
   output logic [7:0]    sram_wdata_o,
   output logic          done_o,
   output logic          soc_rst_o,
   output logic          error_o
);

   localparam logic [AW-1:0] INDEX_LAST = AW'(MEMSIZE - 1);

   boot_state_t   state_reg, state_next;
   logic          active_reg;
   logic [1:0]    addr_cnt_reg;
   logic [AW-1:0] index_reg;
   logic          we_reg, we_next;
   logic [AW-1:0] addr_reg, addr_next;
   logic [7:0]    wdata_reg, wdata_next;
   logic          cs_n_reg, cs_n_next;
   logic          done_reg, done_next;
   logic          soc_rst_reg, soc_rst_next;
   logic [7:0]    tx_data;
   logic [7:0]    rx_data;
   logic          byte_done;

`ifdef BOOT_CHECKSUM_EN
   logic [7:0] sum_reg;
   logic [7:0] check_sum;
   logic       error_reg, error_next;
   assign check_sum = sum_reg + rx_data;
   assign error_o   = error_reg;
`else
   assign error_o   = 1'b0;
`endif

   assign sram_we_o    = we_reg;
   assign sram_addr_o  = addr_reg;
   assign sram_wdata_o = wdata_reg;
   assign spi_cs_no    = cs_n_reg;
   assign done_o       = done_reg;
   assign soc_rst_o    = soc_rst_reg;

   // The first cycle out of reset loads the opcode; SCK only runs while the read is open
   servisia_spi_shifter #(
      .SCK_HALF (SCK_HALF)
   ) u_shifter (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load       (!active_reg),
      .run        (active_reg && spi_active(state_reg)),
      .pause      (state_reg == WRITE),
      .tx_data    (tx_data),
      .spi_miso_i (spi_miso_i),
      .spi_sck_o  (spi_sck_o),
      .spi_mosi_o (spi_mosi_o),
      .rx_data    (rx_data),
      .byte_done  (byte_done)
   );

   // Byte to transmit after the current one: opcode, then the three offset bytes, then zeros
   always_comb begin
      tx_data = 8'h00;
      if (!active_reg) begin
         tx_data = SPI_CMD_READ;
      end else if (state_reg == CMD) begin
         tx_data = FLASH_OFFSET[23:16];
      end else if (state_reg == ADDR) begin
         case (addr_cnt_reg)
            2'd0:    tx_data = FLASH_OFFSET[15:8];
            2'd1:    tx_data = FLASH_OFFSET[7:0];
            default: tx_data = 8'h00;
         endcase
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg    <= CMD;
         active_reg   <= 1'b0;
         addr_cnt_reg <= 2'd0;
         index_reg    <= '0;
         we_reg       <= 1'b0;
         addr_reg     <= '0;
         wdata_reg    <= 8'h00;
         cs_n_reg     <= 1'b1;
         done_reg     <= 1'b0;
         soc_rst_reg  <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
         sum_reg      <= 8'h00;
         error_reg    <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         active_reg  <= 1'b1;
         we_reg      <= we_next;
         addr_reg    <= addr_next;
         wdata_reg   <= wdata_next;
         cs_n_reg    <= cs_n_next;
         done_reg    <= done_next;
         soc_rst_reg <= soc_rst_next;
         if (state_reg == ADDR && byte_done) begin
            addr_cnt_reg <= addr_cnt_reg + 2'd1;
         end
         // Index saturates at the last byte; the FSM leaves WRITE there anyway
         if (state_reg == WRITE && index_reg != INDEX_LAST) begin
            index_reg <= index_reg + AW'(1);
         end
`ifdef BOOT_CHECKSUM_EN
         error_reg <= error_next;
         if (state_next == WRITE) begin
            sum_reg <= sum_reg + rx_data;
         end
`endif
      end
   end

   // Next-state logic: advance on each completed byte, one WRITE cycle per image byte
   always_comb begin
      state_next = state_reg;
      if (active_reg) begin
         unique case (state_reg)
            CMD:   if (byte_done) state_next = ADDR;
            ADDR:  if (byte_done && addr_cnt_reg == 2'd2) state_next = DATA;
            DATA:  if (byte_done) state_next = WRITE;
            WRITE: begin
               if (index_reg == INDEX_LAST) begin
`ifdef BOOT_CHECKSUM_EN
                  state_next = CHECK;
`else
                  state_next = DONE;
`endif
               end else begin
                  state_next = DATA;
               end
            end
`ifdef BOOT_CHECKSUM_EN
            CHECK: if (byte_done) state_next = (check_sum == 8'h00) ? DONE : ERROR;
`endif
            default: state_next = state_reg;
         endcase
      end
   end

   // Output logic: registered outputs follow the state being entered, so they change on the same edge
   always_comb begin
      cs_n_next    = !spi_active(state_next);
      we_next      = (state_next == WRITE);
      addr_next    = addr_reg;
      wdata_next   = wdata_reg;
      done_next    = (state_next == DONE);
      soc_rst_next = (state_next != DONE);
`ifdef BOOT_CHECKSUM_EN
      error_next   = (state_next == ERROR);
`endif
      if (state_next == WRITE) begin
         addr_next  = index_reg;
         wdata_next = rx_data;
      end
   end

endmodule

// File: tb/tb_servisia_boot_loader.sv
// tb_servisia_boot_loader: scoreboard bench for the boot loader with a
// behavioural SPI NOR flash. Stimulus pushes expected flash commands and
// SRAM writes; a monitor pops and compares whenever the DUT presents them.
module tb_servisia_boot_loader;

   localparam int MEMSIZE    = 16;
   localparam int AW         = 4;
   localparam int SCK_HALF   = 1;
   localparam int CLK_PERIOD = 10;
`ifdef BOOT_CHECKSUM_EN
   localparam int EXP_CYCLES = 352;
`else
   localparam int EXP_CYCLES = 336;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          spi_sck, spi_cs_n, spi_mosi, spi_miso;
   logic          sram_we;
   logic [AW-1:0] sram_addr;
   logic [7:0]    sram_wdata;
   logic          done, soc_rst, error;

   servisia_boot_loader #(
      .MEMSIZE  (MEMSIZE),
      .SCK_HALF (SCK_HALF)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .spi_sck_o    (spi_sck),
      .spi_cs_no    (spi_cs_n),
      .spi_mosi_o   (spi_mosi),
      .spi_miso_i   (spi_miso),
      .sram_we_o    (sram_we),
      .sram_addr_o  (sram_addr),
      .sram_wdata_o (sram_wdata),
      .done_o       (done),
      .soc_rst_o    (soc_rst),
      .error_o      (error)
   );

   always #(CLK_PERIOD / 2) clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   wr_t         exp_wr[$];
   logic [31:0] exp_cmd[$];
   logic [31:0] got_cmd[$];
   wr_t         mon_e;
   logic [31:0] mon_cmd;

   int   errors    = 0;
   int   checks    = 0;
   int   wr_count  = 0;
   int   idle_sck  = 0;
   int   sck_rises = 0;
   time  t_rise2   = 0;
   time  t_rise3   = 0;

   logic [7:0] img [17];

   // Flash model state
   int          fl_bits  = 0;
   int          fl_n     = 0;
   logic [31:0] fl_shift = '0;
   logic [7:0]  fl_byte  = '0;
   logic        model_miso = 1'b0;
   logic        toggle_en  = 1'b0;
   logic        toggle_val = 1'b0;

   assign spi_miso = toggle_en ? toggle_val : model_miso;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_sck"},     32'(spi_sck),    0);
      check({tag, "_cs_n"},    32'(spi_cs_n),   1);
      check({tag, "_mosi"},    32'(spi_mosi),   0);
      check({tag, "_we"},      32'(sram_we),    0);
      check({tag, "_addr"},    32'(sram_addr),  0);
      check({tag, "_wdata"},   32'(sram_wdata), 0);
      check({tag, "_done"},    32'(done),       0);
      check({tag, "_soc_rst"}, 32'(soc_rst),    1);
      check({tag, "_error"},   32'(error),      0);
   endtask

   // Expected transactions of one complete load: read command, then one write per image byte
   task automatic push_load();
      wr_t w;
      exp_cmd.push_back({8'h03, 24'h100000});
      for (int i = 0; i < MEMSIZE; i++) begin
         w.addr = AW'(i);
         w.data = img[5'(i)];
         exp_wr.push_back(w);
      end
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (!(done || error) && cycles < 2000) begin
         @(posedge clk);
         cycles++;
         #1;
      end
      if (!(done || error)) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got done=%0b error=%0b after %0d cycles, required done or error", done, error, cycles);
      end
   endtask

   // Flash: collect 32 command/address bits on rising SCK, reset when deselected
   always @(posedge spi_sck or posedge spi_cs_n) begin
      if (spi_cs_n) begin
         fl_bits = 0;
      end else begin
         if (fl_bits < 32) fl_shift = {fl_shift[30:0], spi_mosi};
         fl_bits++;
         if (fl_bits == 32) got_cmd.push_back(fl_shift);
      end
   end

   // Flash: present the next data bit after each falling SCK (mode 0)
   always @(negedge spi_sck) begin
      if (!spi_cs_n && fl_bits >= 32) begin
         fl_n = fl_bits - 32;
         if (fl_n / 8 <= MEMSIZE) begin
            fl_byte    = img[5'(fl_n / 8)];
            model_miso = fl_byte[3'(7 - (fl_n % 8))];
         end
      end
   end

   // SCK activity: idle-clock detection and early period sampling
   always @(posedge spi_sck) begin
      if (spi_cs_n) idle_sck++;
      sck_rises++;
      if (sck_rises == 2) t_rise2 = $time;
      if (sck_rises == 3) t_rise3 = $time;
   end

   // Monitor: compare every write strobe and every received flash command against the scoreboard
   always @(negedge clk) begin
      if (sram_we) begin
         wr_count++;
         $display("write addr=%0d data=0x%02h", sram_addr, sram_wdata);
         if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL write_unexpected: got addr=%0d data=0x%02h, required no write", sram_addr, sram_wdata);
         end else begin
            mon_e = exp_wr.pop_front();
            check("write_addr", 32'(sram_addr), 32'(mon_e.addr));
            check("write_data", 32'(sram_wdata), 32'(mon_e.data));
         end
      end
      if (got_cmd.size() != 0) begin
         mon_cmd = got_cmd.pop_front();
         $display("flash cmd=0x%08h", mon_cmd);
         if (exp_cmd.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cmd_unexpected: got 0x%08h, required no command", mon_cmd);
         end else begin
            check("flash_cmd", mon_cmd, exp_cmd.pop_front());
         end
      end
   end

   initial begin
      int          cyc;
      int          wr_base;
      int          changes;
      logic [18:0] snap;
      logic [18:0] cur;

      for (int i = 0; i < MEMSIZE; i++) img[5'(i)] = 8'(i);
      img[16] = 8'h88;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_reset("rst");

      // Full load: command, 16 writes, cycle count, final outputs
      push_load();
      wr_base = wr_count;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("cs_n_before_first_edge", 32'(spi_cs_n), 1);
      @(posedge clk);
      #1;
      check("cs_n_after_release", 32'(spi_cs_n), 0);
      wait_done(cyc);
      check("load_cycles", 32'(cyc), EXP_CYCLES);
      check("sck_period", 32'(t_rise3 - t_rise2), 2 * CLK_PERIOD);
      check("done_after_load", 32'(done), 1);
      check("soc_rst_after_load", 32'(soc_rst), 0);
      check("cs_n_after_load", 32'(spi_cs_n), 1);
      check("sck_after_load", 32'(spi_sck), 0);
      check("error_after_load", 32'(error), 0);
      check("writes_in_load", 32'(wr_count - wr_base), MEMSIZE);

      // MISO noise after DONE must not disturb anything
      wr_base = wr_count;
      changes = 0;
      snap = {spi_sck, spi_cs_n, spi_mosi, sram_we, sram_addr, sram_wdata, done, soc_rst, error};
      toggle_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         toggle_val = ~toggle_val;
         #1;
         cur = {spi_sck, spi_cs_n, spi_mosi, sram_we, sram_addr, sram_wdata, done, soc_rst, error};
         if (cur !== snap) changes++;
      end
      toggle_en = 1'b0;
      check("outputs_changed_after_done", 32'(changes), 0);
      check("writes_after_done", 32'(wr_count - wr_base), 0);

      // Reset after the 5th write, then a clean reload from index 0
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      push_load();
      wr_base = wr_count;
      rst = 1'b0;
      for (int i = 0; i < 1000 && (wr_count - wr_base) < 5; i++) @(posedge clk);
      check("writes_before_reset", 32'(wr_count - wr_base), 5);
      #2;
      rst = 1'b1;
      #1;
      check_reset("midrst");
      exp_wr.delete();
      @(negedge clk);
      push_load();
      wr_base = wr_count;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("cs_n_reload", 32'(spi_cs_n), 0);
      wait_done(cyc);
      check("done_after_reload", 32'(done), 1);
      check("writes_in_reload", 32'(wr_count - wr_base), MEMSIZE);

`ifdef BOOT_CHECKSUM_EN
      // Bad trailer: all 16 bytes written, then ERROR holds the SoC in reset
      @(negedge clk);
      rst = 1'b1;
      img[16] = 8'h00;
      @(negedge clk);
      push_load();
      wr_base = wr_count;
      rst = 1'b0;
      wait_done(cyc);
      check("error_bad_sum", 32'(error), 1);
      check("done_bad_sum", 32'(done), 0);
      check("soc_rst_bad_sum", 32'(soc_rst), 1);
      check("cs_n_bad_sum", 32'(spi_cs_n), 1);
      check("writes_bad_sum", 32'(wr_count - wr_base), MEMSIZE);
`endif

      // Drain and final scoreboard state
      repeat (3) @(negedge clk);
      check("exp_writes_left", 32'(exp_wr.size()), 0);
      check("exp_cmds_left", 32'(exp_cmd.size()), 0);
      check("sck_while_deselected", 32'(idle_sck), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
